// File: rtl/pio_gpio_pkg.sv
// Shared constants for the pio_gpio_irq Avalon-MM GPIO slave.
// No logic: register map, edge-type and irq-type selectors.
// No flow control: constants only.
package pio_gpio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_edge_sync.sv
// Pin synchroniser plus one-cycle history and edge detector.
// sync_in lags in_port by SYNC_STAGES cycles; edge_det is combinational from sync_in/prev.
// No backpressure: samples every cycle.
module pio_edge_sync
    import pio_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_TYPE == EDGE_RISE) begin : g_rise
            assign edge_det = sync_in & ~prev;
        end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_det = ~sync_in & prev;
        end else begin : g_any
            assign edge_det = sync_in ^ prev;
        end
    endgenerate

endmodule

// File: rtl/pio_gpio_irq.sv
// Avalon-MM GPIO: output register with set/clear, direction, edge capture, maskable irq.
// Reads registered with fixed latency 1; writes take effect next cycle; irq is combinational.
// No backpressure: every access completes without wait states.
module pio_gpio_irq
    import pio_gpio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               IRQ_TYPE    = 1,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("pio_gpio_irq: WIDTH must be 1..32");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
            $error("pio_gpio_irq: SYNC_STAGES must be 2..3");
        end
        if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge
            $error("pio_gpio_irq: EDGE_TYPE must be 0..2");
        end
        if (IRQ_TYPE < 0 || IRQ_TYPE > 1) begin : g_bad_irq
            $error("pio_gpio_irq: IRQ_TYPE must be 0..1");
        end
    endgenerate

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wd;
    logic             unused_writedata;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & write_n;
    assign wd    = writedata[WIDTH-1:0];
    // Bits above WIDTH are architecturally ignored.
    assign unused_writedata = ^writedata;

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_det;

    pio_edge_sync #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .sync_in  (sync_in),
        .edge_det (edge_det)
    );

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] direction;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out  <= RESET_VALUE;
            direction <= '0;
            mask      <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data_out  <= wd;
                ADDR_DIR:    direction <= wd;
                ADDR_MASK:   mask      <= wd;
                ADDR_OUTSET: data_out  <= data_out | wd;
                ADDR_OUTCLR: data_out  <= data_out & ~wd;
                default:     ;
            endcase
        end
    end

    assign edge_clr = (wr_en && address == ADDR_EDGE) ? wd : '0;

    // Clear is applied before the new edge is OR-ed in, so a coincident edge wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clr) | edge_det;
        end
    end

    logic [31:0] rd_next;

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:   rd_next[WIDTH-1:0] = sync_in;
            ADDR_DIR:    rd_next[WIDTH-1:0] = direction;
            ADDR_MASK:   rd_next[WIDTH-1:0] = mask;
            ADDR_EDGE:   rd_next[WIDTH-1:0] = edge_capture;
            ADDR_OUTSET: rd_next[WIDTH-1:0] = data_out;
            ADDR_OUTCLR: rd_next[WIDTH-1:0] = data_out;
            default:     rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_next;
        end
    end

    assign out_port = data_out;
    assign oe       = direction;

    generate
        if (IRQ_TYPE == IRQ_EDGE) begin : g_irq_edge
            assign irq = |(edge_capture & mask);
        end else begin : g_irq_level
            assign irq = |(sync_in & mask);
        end
    endgenerate

endmodule

// File: tb/tb_pio_gpio_irq.sv
// Scoreboard bench for pio_gpio_irq: random and directed bus/pin stimulus against a register-level model.
module tb_pio_gpio_irq;
    import pio_gpio_pkg::*;

    localparam int         W  = 8;
    localparam int         S  = 2;
    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    pio_gpio_irq #(
        .WIDTH(W), .RESET_VALUE(RV), .EDGE_TYPE(EDGE_RISE), .IRQ_TYPE(IRQ_EDGE), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
    );

    logic [2:0]  address32;
    logic        cs32;
    logic        wn32;
    logic [31:0] wd32;
    logic [31:0] rd32;
    logic [31:0] in32;
    logic [31:0] out32;
    logic [31:0] oe32;
    logic        irq32;

    pio_gpio_irq #(
        .WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(EDGE_ANY), .IRQ_TYPE(IRQ_EDGE), .SYNC_STAGES(3)
    ) dut32 (
        .clk(clk), .reset_n(reset_n), .address(address32), .chipselect(cs32),
        .write_n(wn32), .writedata(wd32), .readdata(rd32),
        .in_port(in32), .out_port(out32), .oe(oe32), .irq(irq32)
    );

    // Reference model: architectural registers plus the raw pin history.
    logic [7:0]  m_data, m_dir, m_mask, m_edge;
    logic [7:0]  pin_hist [0:S];
    logic [31:0] expq [$];
    bit          rd_due;
    bit          chk_en;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data = RV;
        m_dir  = '0;
        m_mask = '0;
        m_edge = '0;
        for (int i = 0; i <= S; i++) pin_hist[i] = '0;
        expq.delete();
        rd_due = 0;
    endtask

    // Applied at each rising edge with the inputs the DUT sees at that edge.
    // The synchronised pin value seen this cycle is the pin as sampled S edges ago.
    task automatic model_edge();
        logic [7:0] pin_now, pin_before, rose, wd, clr, rv;
        if (!reset_n) return;
        pin_now    = pin_hist[S-1];
        pin_before = pin_hist[S];
        rose       = pin_now & ~pin_before;
        wd         = writedata[7:0];
        if (chipselect && write_n) begin
            case (address)
                3'd0:    rv = pin_now;
                3'd1:    rv = m_dir;
                3'd2:    rv = m_mask;
                3'd3:    rv = m_edge;
                3'd4:    rv = m_data;
                3'd5:    rv = m_data;
                default: rv = 8'h00;
            endcase
            expq.push_back({24'h0, rv});
            rd_due = 1;
        end
        clr = 8'h00;
        if (chipselect && !write_n) begin
            case (address)
                3'd0: m_data = wd;
                3'd1: m_dir  = wd;
                3'd2: m_mask = wd;
                3'd3: clr    = wd;
                3'd4: m_data = m_data | wd;
                3'd5: m_data = m_data & ~wd;
                default: ;
            endcase
        end
        m_edge = (m_edge & ~clr) | rose;
        for (int i = S; i > 0; i--) pin_hist[i] = pin_hist[i-1];
        pin_hist[0] = in_port;
    endtask

    // Monitor: compares outputs every cycle and pops read responses when due.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_port", {24'h0, out_port}, {24'h0, m_data});
            check("oe", {24'h0, oe}, {24'h0, m_dir});
            check("irq", {31'h0, irq}, {31'h0, |(m_edge & m_mask)});
            if (rd_due) begin
                rd_due = 0;
                if (expq.size() == 0) begin
                    check("rd_queue_empty", 32'd1, 32'd0);
                end else begin
                    check("readdata", readdata, expq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
    endtask

    task automatic rd(input logic [2:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        chipselect = 0; write_n = 1; address = 0; writedata = 0; in_port = 0;
        cs32 = 0; wn32 = 1; address32 = 0; wd32 = 0; in32 = 0;
        chk_en = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1;

        check("rst_out_port", {24'h0, out_port}, 32'hA5);
        check("rst_oe", {24'h0, oe}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        for (int a = 0; a < 6; a++) rd(3'(a));
        tick();

        wr(3'd0, 32'h0000_000F);
        check("set_data", {24'h0, out_port}, 32'h0F);
        wr(3'd4, 32'hFFFF_FFF0);
        check("outset", {24'h0, out_port}, 32'hFF);
        wr(3'd5, 32'h0000_0081);
        check("outclr", {24'h0, out_port}, 32'h7E);

        // Rising edge on bit 3 reaches edge_capture after S+1 edges.
        wr(3'd2, 32'h08);
        in_port[3] = 1'b1;
        for (int i = 1; i <= S + 1; i++) begin
            tick();
            check("edge_latency", {31'h0, irq}, {31'h0, (i == S + 1)});
        end
        rd(3'd3);
        check("edge_cap", readdata, 32'h08);
        in_port[3] = 1'b0;
        repeat (S + 2) tick();
        wr(3'd3, 32'h08);
        check("irq_clr", {31'h0, irq}, 32'h0);
        rd(3'd3);
        check("fall_noset", readdata, 32'h0);

        in_port[3] = 1'b1;
        repeat (S + 1) tick();
        wr(3'd2, 32'h00);
        check("irq_masked", {31'h0, irq}, 32'h0);
        rd(3'd3);
        check("cap_kept", readdata, 32'h08);

        // Edge on bit 2 lands on the same edge as its clear.
        in_port[2] = 1'b1;
        tick();
        tick();
        wr(3'd3, 32'h04);
        rd(3'd3);
        check("set_wins", {31'h0, readdata[2]}, 32'h1);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                address    = 3'($urandom_range(0, 7));
                chipselect = 1'b1;
                write_n    = 1'($urandom_range(0, 1));
                writedata  = $urandom;
            end
            tick();
        end

        address32 = 3'd1; cs32 = 1; wn32 = 0; wd32 = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("w32_oe", oe32, 32'hDEADBEEF);
        wn32 = 1;
        @(posedge clk); #1;
        cs32 = 0;
        check("w32_read", rd32, 32'hDEADBEEF);
        tick();

        // Asynchronous reset with irq high and a read response held.
        wr(3'd0, 32'h3C);
        wr(3'd2, 32'hFF);
        in_port = 8'h00;
        repeat (S + 2) tick();
        in_port = 8'h01;
        repeat (S + 1) tick();
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        rd(3'd4);
        check("pre_rst_rd", readdata, 32'h3C);
        #2;
        chk_en  = 0;
        reset_n = 1'b0;
        #1;
        check("arst_irq", {31'h0, irq}, 32'h0);
        check("arst_out_port", {24'h0, out_port}, 32'hA5);
        check("arst_readdata", readdata, 32'h0);
        check("arst_rd32", rd32, 32'h0);
        check("arst_oe32", oe32, 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1;
        rd(3'd3);
        rd(3'd3);
        repeat (S + 2) tick();
        rd(3'd3);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_gpio_irq.md
Name: pio_gpio_irq

Overview:
- Parametrised Avalon-MM general-purpose I/O port for the MAX10NIOS system, generalising the single-bit output PIO.
- Provides a WIDTH-bit output register, per-bit direction control, input synchronisation, atomic bit set/clear, and per-bit edge capture.
- Has a maskable interrupt output and sits on the Nios II data master as a slave with fixed read latency 1.

Parameters:
- WIDTH, 8: port width in bits; legal range 1..32.
- RESET_VALUE, 0: reset value of data_out, WIDTH bits.
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge.
- IRQ_TYPE, 1: 0 = level (synced input & mask), 1 = edge (edge_capture & mask).
- SYNC_STAGES, 2: input synchroniser depth; legal range 2..3.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  registered read data; bits above WIDTH are 0.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  per-bit output enable (= direction register).
- irq  out  1  interrupt request, active-high.

Behaviour:
- Reset:
  - data_out = RESET_VALUE; direction, mask, edge_capture, readdata, synchroniser and prev flops = 0.
  - irq = 0; oe = 0 (all inputs).
- Write (chipselect & ~write_n), by address:
  - 0 data_out := writedata[WIDTH-1:0].
  - 1 direction := wd.
  - 2 mask := wd.
  - 3 edge_capture &= ~wd (write-1-to-clear).
  - 4 data_out |= wd (set).
  - 5 data_out &= ~wd (clear).
  - 6, 7 ignored.
- Read (chipselect & write_n):
  - readdata is registered one cycle after the access; readLatency = 1.
  - By address: 0 sync_in; 1 direction; 2 mask; 3 edge_capture; 4, 5 data_out; 6, 7 zero.
  - Reads have no side effects.
  - readdata holds its last value when not selected.
- Synchroniser:
  - in_port passes through SYNC_STAGES flops to give sync_in; prev = sync_in delayed 1 cycle.
  - Edge detect:
    - rise = sync_in & ~prev
    - fall = ~sync_in & prev
    - any = sync_in ^ prev
  - Pin change to edge_capture set latency: SYNC_STAGES+1 cycles.
- Edge capture:
  - A bit sets on a detected edge regardless of direction and mask.
  - It holds until cleared.
  - If an edge and a write-1-to-clear hit the same bit in the same cycle, set wins.
- irq:
  - Combinational OR of (edge_capture & mask) when IRQ_TYPE = 1.
  - Combinational OR of (sync_in & mask) when IRQ_TYPE = 0.
  - Deasserts the cycle after the clearing write or mask write.
- Direction:
  - oe = direction.
  - out_port is always driven from data_out; the tristate buffer is external.
  - Address 0 reads sync_in (the pin value), so an output bit loops back only through the external pad.
- Reset mid-operation:
  - Asynchronously clears all state, including pending edges; irq drops immediately.
  - A read in flight returns 0.
- Width rules:
  - WIDTH = 32 uses the full bus.
  - WIDTH < 32: writes truncate and reads zero-extend.
  - An out-of-range parameter is an elaboration error.

Decomposition:
- Package pio_gpio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2, ADDR_EDGE=3, ADDR_OUTSET=4, ADDR_OUTCLR=5;
  - EDGE_RISE/EDGE_FALL/EDGE_ANY;
  - IRQ_LEVEL/IRQ_EDGE.
- One sub-module, pio_edge_sync, contains:
  - the per-port SYNC_STAGES synchroniser;
  - the prev register;
  - the EDGE_TYPE edge detector, outputting sync_in and edge[WIDTH-1:0].
- The top module keeps the register file, read mux and irq.

Test Plan:
- Reset with RESET_VALUE=8'hA5: release reset -> out_port=8'hA5, oe=0, irq=0; read addr 0..5 -> 0, 0, 0, 0, A5, A5 after 1-cycle latency.
- Atomic ops: write 8'h0F to addr 0, 8'hF0 to addr 4, then 8'h81 to addr 5 -> out_port 0F, FF, 7E on successive cycles.
- Edge capture (EDGE_TYPE=0):
  - toggle in_port[3] 0->1 -> edge_capture=8'h08 exactly SYNC_STAGES+1 cycles later;
  - a 1->0 change -> no further set.
- Interrupt:
  - mask=8'h08 with the captured bit -> irq=1;
  - write 8'h08 to addr 3 -> irq=0 next cycle;
  - mask=0 with capture set -> irq=0.
- Simultaneous set/clear: edge on bit 2 in the same cycle as a clear write of 8'h04 -> bit 2 remains 1.
- Asynchronous reset asserted mid-transfer with irq=1 -> irq, out_port, readdata drop without a clock edge; WIDTH=32 readback of 32'hDEADBEEF at addr 1 returns exact.
